// File: rtl/pixel_block_loader_pkg.sv
// Shared constants and bank-state type for the pixel block loader
// and the input_array_mux benches.
package pixel_block_loader_pkg;

  localparam int PIX_W = 8;
  localparam int BLK   = 15;
  localparam int CNT_W = 16;
  localparam int NPIX  = BLK * BLK;
  localparam int BUS_W = NPIX * PIX_W;
  localparam int RC_W  = $clog2(BLK);
  localparam int IDX_W = $clog2(NPIX);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

endpackage

// File: rtl/pixel_block_loader_raster_counter.sv
// Row/column raster counter with wrap, sof restart
// and a last-beat flag for the block loader.
module pbl_raster_counter
  import pixel_block_loader_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            step,
  input  logic            sof,
  output logic [RC_W-1:0] wr_row,
  output logic [RC_W-1:0] wr_col,
  output logic            resync,
  output logic            last
);

  localparam logic [RC_W-1:0] EDGE = RC_W'(BLK - 1);

  logic [RC_W-1:0] row;
  logic [RC_W-1:0] col;

  // An sof away from the origin redirects the beat to (0,0).
  assign resync = sof && (row != '0 || col != '0);
  assign wr_row = resync ? '0 : row;
  assign wr_col = resync ? '0 : col;
  assign last   = !resync && row == EDGE
               && col == EDGE;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row <= '0;
      col <= '0;
    end else if (step) begin
      if (resync) begin
        row <= '0;
        col <= RC_W'(1);
      end else if (col == EDGE) begin
        col <= '0;
        row <= (row == EDGE) ? '0
             : row + RC_W'(1);
      end else begin
        col <= col + RC_W'(1);
      end
    end
  end

endmodule

// File: rtl/pixel_block_loader.sv
// Raster stream to ping-pong 15x15 pixel banks, presenting the
// finished bank as a flat bus with a valid/ack handshake.
module pixel_block_loader
  import pixel_block_loader_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             in_sof,
  output logic [BUS_W-1:0] integer_array,
  output logic             array_valid,
  input  logic             array_ack,
  output logic             sof_err,
  output logic [CNT_W-1:0] block_count
);

  bank_state_t      st   [2];
  bank_state_t      st_n [2];
  logic [BUS_W-1:0] bank [2];
  logic             wr_bank;
  logic             rd_bank;
  logic             rd_n;
  logic             alive;
  logic [RC_W-1:0]  wr_row;
  logic [RC_W-1:0]  wr_col;
  logic [IDX_W-1:0] wr_idx;
  logic             resync;
  logic             last;
  logic             take;
  logic             rel;

  pbl_raster_counter u_cnt (
    .clock  (clock),
    .reset  (reset),
    .step   (take),
    .sof    (in_sof),
    .wr_row (wr_row),
    .wr_col (wr_col),
    .resync (resync),
    .last   (last)
  );

  assign in_ready = alive && st[wr_bank] != FULL;
  assign take     = in_valid && in_ready;
  assign rel      = array_ack && array_valid;
  assign wr_idx   = IDX_W'(wr_row) * IDX_W'(BLK)
                  + IDX_W'(wr_col);
  assign integer_array = bank[rd_bank];

  // A fill and a release never touch the same bank: a release
  // needs the read bank FULL, which blocks writes into it.
  always_comb begin
    st_n = st;
    rd_n = rd_bank;
    if (take) st_n[wr_bank] = last ? FULL : FILLING;
    if (rel) begin
      st_n[rd_bank] = EMPTY;
      rd_n          = ~rd_bank;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st[0]       <= EMPTY;
      st[1]       <= EMPTY;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      alive       <= 1'b0;
      array_valid <= 1'b0;
      sof_err     <= 1'b0;
      block_count <= '0;
    end else begin
      alive       <= 1'b1;
      st          <= st_n;
      rd_bank     <= rd_n;
      array_valid <= st_n[rd_n] == FULL;
      sof_err     <= take && resync;
      if (take && last) begin
        wr_bank     <= ~wr_bank;
        block_count <= block_count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bank[0] <= '0;
      bank[1] <= '0;
    end else begin
      for (int p = 0; p < NPIX; p++) begin
        if (take && wr_idx == IDX_W'(p))
          bank[wr_bank][PIX_W*p +: PIX_W] <= in_pixel;
      end
    end
  end

endmodule

// File: tb/tb_pixel_block_loader.sv
// Directed and randomised-backpressure bench for pixel_block_loader
// with a queue-based block scoreboard.
module tb_pixel_block_loader;
  import pixel_block_loader_pkg::*;

  typedef logic [BUS_W-1:0] blk_t;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [PIX_W-1:0] in_pixel = '0;
  logic             in_sof = 1'b0;
  logic [BUS_W-1:0] integer_array;
  logic             array_valid;
  logic             array_ack = 1'b0;
  logic             sof_err;
  logic [CNT_W-1:0] block_count;

  pixel_block_loader dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pixel      (in_pixel),
    .in_sof        (in_sof),
    .integer_array (integer_array),
    .array_valid   (array_valid),
    .array_ack     (array_ack),
    .sof_err       (sof_err),
    .block_count   (block_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int sof_pulses = 0;
  bit auto_ack = 1'b0;

  // model: pixels of the block in flight, finished blocks awaiting ack
  logic [PIX_W-1:0] cur[$];
  blk_t             exp_q[$];
  bit               alive = 1'b0;
  bit               exp_sof = 1'b0;
  int unsigned      blocks = 0;
  bit               rdy;
  blk_t             nb;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [PIX_W-1:0] pix_at(input blk_t b,
                                               input int r,
                                               input int c);
    return b[PIX_W*c + PIX_W*BLK*r +: PIX_W];
  endfunction

  // compare outputs, then advance the model across the next edge
  always @(negedge clock) begin
    if (!reset) begin
      cur.delete();
      exp_q.delete();
      alive = 1'b0;
      exp_sof = 1'b0;
      blocks = 0;
    end else begin
      chk("in_ready", in_ready, alive && exp_q.size() < 2);
      chk("array_valid", array_valid, exp_q.size() > 0);
      chk("sof_err", sof_err, exp_sof);
      chk("block_count", block_count, blocks & 32'hFFFF);
      if (exp_q.size() > 0) begin
        total++;
        if (integer_array !== exp_q[0]) begin
          bad++;
          for (int i = 0; i < NPIX; i++) begin
            if (integer_array[PIX_W*i +: PIX_W]
                !== exp_q[0][PIX_W*i +: PIX_W]) begin
              $display("FAIL bus pixel %0d: got %h want %h", i,
                       integer_array[PIX_W*i +: PIX_W],
                       exp_q[0][PIX_W*i +: PIX_W]);
              break;
            end
          end
        end
      end
      if (sof_err) sof_pulses++;
      exp_sof = 1'b0;
      rdy = alive && exp_q.size() < 2;
      if (in_valid && rdy) begin
        if (in_sof && cur.size() > 0) begin
          cur.delete();
          exp_sof = 1'b1;
        end
        cur.push_back(in_pixel);
        if (cur.size() == NPIX) begin
          for (int i = 0; i < NPIX; i++)
            nb[PIX_W*i +: PIX_W] = cur[i];
          exp_q.push_back(nb);
          blocks++;
          cur.delete();
        end
      end
      if (array_ack && exp_q.size() > 0 && array_valid)
        void'(exp_q.pop_front());
      alive = 1'b1;
    end
  end

  always @(posedge clock) begin
    #1;
    if (auto_ack)
      array_ack = array_valid && ($urandom_range(3) == 0);
  end

  task automatic beat(input logic [PIX_W-1:0] p, input logic s);
    int n;
    logic acc;
    n = 0;
    in_valid = 1'b1;
    in_pixel = p;
    in_sof = s;
    do begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
      n++;
    end while (!acc && n < 3000);
    if (!acc) begin
      $display("FAIL beat_timeout: got stalled want accepted");
      bad++;
      total++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "stream stalled");
    end
  endtask

  task automatic send_block(input int base, input bit sof0,
                            input bit rnd, input int gap_pct);
    logic [PIX_W-1:0] p;
    for (int i = 0; i < NPIX; i++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(posedge clock);
          #1;
        end
      end
      p = rnd ? PIX_W'($urandom) : PIX_W'(base + i);
      beat(p, sof0 && i == 0);
    end
    in_valid = 1'b0;
    in_sof = 1'b0;
  endtask

  task automatic ack_once();
    array_ack = 1'b1;
    @(posedge clock);
    #1;
    array_ack = 1'b0;
  endtask

  initial begin
    int n;
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_valid", array_valid, 0);
    chk("rst_count", block_count, 0);
    chk("rst_bus", |integer_array, 0);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    chk("ready_after_release", in_ready, 1);

    // single block, pixel = r*15+c
    send_block(0, 1'b1, 1'b0, 0);
    chk("single_lat1", array_valid, 1);
    chk("single_p00", pix_at(integer_array, 0, 0), 0);
    chk("single_p10", pix_at(integer_array, 1, 0), 15);
    chk("single_p_10_3", pix_at(integer_array, 10, 3), 153);
    chk("single_p_14_14", pix_at(integer_array, 14, 14), 224);
    chk("single_count", block_count, 1);
    ack_once();

    // ping-pong: A then B with no ack
    send_block(16, 1'b1, 1'b0, 0);
    send_block(128, 1'b1, 1'b0, 0);
    chk("pp_ready_low", in_ready, 0);
    chk("pp_busA", pix_at(integer_array, 0, 0), 16);
    ack_once();
    chk("pp_busB_00", pix_at(integer_array, 0, 0), 128);
    chk("pp_busB_ee", pix_at(integer_array, 14, 14), 96);
    chk("pp_valid", array_valid, 1);
    chk("pp_ready_up", in_ready, 1);
    chk("pp_count", block_count, 3);

    // overlap: ack B on the same edge as C's last beat
    for (int i = 0; i < NPIX - 1; i++)
      beat(PIX_W'(64 + i), i == 0);
    array_ack = 1'b1;
    beat(PIX_W'(64 + NPIX - 1), 1'b0);
    array_ack = 1'b0;
    in_valid = 1'b0;
    chk("ov_valid", array_valid, 1);
    chk("ov_busC_00", pix_at(integer_array, 0, 0), 64);
    chk("ov_busC_ee", pix_at(integer_array, 14, 14), 32);
    chk("ov_count", block_count, 4);
    ack_once();
    chk("ov_drained", array_valid, 0);

    // resync on beat index 40
    for (int i = 0; i < 40; i++)
      beat(PIX_W'(200 + i), i == 0);
    beat(PIX_W'(240), 1'b1);
    for (int k = 1; k < NPIX; k++)
      beat(PIX_W'(240 + k), 1'b0);
    in_valid = 1'b0;
    chk("rs_pulses", sof_pulses, 1);
    chk("rs_valid", array_valid, 1);
    chk("rs_p00", pix_at(integer_array, 0, 0), 240);
    chk("rs_p01", pix_at(integer_array, 0, 1), 241);
    chk("rs_p_ee", pix_at(integer_array, 14, 14), 208);
    chk("rs_count", block_count, 5);
    ack_once();

    // backpressure: random gaps, random ack delays, 50 blocks
    auto_ack = 1'b1;
    repeat (50) send_block(0, 1'($urandom_range(1)), 1'b1, 30);
    n = 0;
    while (array_valid && n < 2000) begin
      @(posedge clock);
      #1;
      n++;
    end
    auto_ack = 1'b0;
    array_ack = 1'b0;
    chk("bp_drained", array_valid, 0);
    chk("bp_count", block_count, 55);
    chk("bp_no_sof_err", sof_pulses, 1);

    // async reset while a block is valid and the next is partial
    send_block(10, 1'b1, 1'b0, 0);
    for (int i = 0; i < 50; i++)
      beat(PIX_W'(i), i == 0);
    chk("ar_pre_valid", array_valid, 1);
    #1 reset = 1'b0;
    #1;
    chk("ar_valid", array_valid, 0);
    chk("ar_ready", in_ready, 0);
    chk("ar_count", block_count, 0);
    chk("ar_bus", |integer_array, 0);
    chk("ar_sof_err", sof_err, 0);
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    #1;
    send_block(100, 1'b1, 1'b0, 0);
    chk("ar_new_valid", array_valid, 1);
    chk("ar_new_count", block_count, 1);
    chk("ar_new_p00", pix_at(integer_array, 0, 0), 100);
    chk("ar_new_p_ee", pix_at(integer_array, 14, 14), 68);
    ack_once();
    repeat (3) @(posedge clock);
    #1;
    chk("end_idle", array_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
